number_rom_arbiter: RTL and testbench

- Shares the single glyph ROM (`numbers`) among three on-screen digit requesters: time display, score display, and best-score display.
- Replaces the ad-hoc OR-merge of `selected_number` / `number_count`.
- Each clock it grants at most one requester by round-robin, drives the ROM address registered, and returns the ROM pixel tagged with its owner after the ROM latency.
- Sits between the display controllers, the `numbers` ROM, and the VGA colour mux.

---
 rtl/number_rom_arbiter.sv | 129 ++++++++++++
 tb/tb_number_rom_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/number_rom_arbiter.sv
// Round-robin arbiter sharing the single glyph ROM among the time, score and
// best-score digit requesters, returning each ROM pixel tagged with its owner.
module number_rom_arbiter #(
  parameter int ROM_LATENCY   = 1,
  parameter int CONFLICT_BITS = 8
) (
  input  logic                     clock_25,
  input  logic                     reset,
  input  logic                     sync_reset,
  input  logic [2:0]               req,
  input  logic [3:0]               selected_number_0,
  input  logic [3:0]               selected_number_1,
  input  logic [3:0]               selected_number_2,
  input  logic [7:0]               number_count_0,
  input  logic [7:0]               number_count_1,
  input  logic [7:0]               number_count_2,
  output logic [2:0]               grant,
  output logic [2:0]               denied,
  output logic [3:0]               rom_selected_number,
  output logic [7:0]               rom_number_count,
  input  logic                     number_pixel,
  output logic                     pixel_valid,
  output logic [1:0]               pixel_owner,
  output logic                     pixel_out,
  output logic [CONFLICT_BITS-1:0] conflict_count
);

  // Stage A plus ROM_LATENCY stages keeps the tag aligned with the ROM data.
  localparam int STAGES = ROM_LATENCY + 1;

  logic       clr;
  logic [1:0] ptr;
  logic [1:0] cand;
  logic [1:0] win;
  logic       win_any;
  logic [2:0] win_oh;
  logic [3:0] win_sn;
  logic [7:0] win_nc;
  logic       multi;

  logic [STAGES-1:0] vld_p;
  logic [1:0]        own_p [STAGES];

  function automatic logic [1:0] rr_next(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  function automatic logic [CONFLICT_BITS-1:0] sat_inc(input logic [CONFLICT_BITS-1:0] v);
    return (&v) ? v : v + CONFLICT_BITS'(1);
  endfunction

  assign clr = reset | sync_reset;

  always_comb begin
    win_any = 1'b0;
    win     = 2'd0;
    cand    = ptr;
    for (int k = 0; k < 3; k++) begin
      if (!win_any && req[cand]) begin
        win_any = 1'b1;
        win     = cand;
      end
      cand = rr_next(cand);
    end
  end

  // Idle cycles drive a zero address so the bus matches the legacy OR-merge.
  always_comb begin
    win_oh = 3'b000;
    win_sn = 4'd0;
    win_nc = 8'd0;
    if (win_any) begin
      win_oh = 3'b001 << win;
      case (win)
        2'd0: begin
          win_sn = selected_number_0;
          win_nc = number_count_0;
        end
        2'd1: begin
          win_sn = selected_number_1;
          win_nc = number_count_1;
        end
        default: begin
          win_sn = selected_number_2;
          win_nc = number_count_2;
        end
      endcase
    end
  end

  assign multi = (req[0] & req[1]) | (req[0] & req[2]) | (req[1] & req[2]);

  // Stage A: grant, ROM address, pointer and conflict statistics.
  always_ff @(posedge clock_25) begin
    if (clr) begin
      grant               <= 3'b000;
      denied              <= 3'b000;
      rom_selected_number <= 4'd0;
      rom_number_count    <= 8'd0;
      ptr                 <= 2'd0;
      conflict_count      <= '0;
    end else begin
      grant               <= win_oh;
      denied              <= req & ~win_oh;
      rom_selected_number <= win_sn;
      rom_number_count    <= win_nc;
      if (win_any) ptr <= rr_next(win);
      if (multi) conflict_count <= sat_inc(conflict_count);
    end
  end

  // Tag stages p0..pN: {valid, owner} follows the address through the ROM.
  always_ff @(posedge clock_25) begin
    if (clr) begin
      vld_p <= '0;
      for (int k = 0; k < STAGES; k++) own_p[k] <= 2'd0;
    end else begin
      vld_p    <= {vld_p[STAGES-2:0], win_any};
      own_p[0] <= win;
      for (int k = 1; k < STAGES; k++) own_p[k] <= own_p[k-1];
    end
  end

  // ROM data lands in the same cycle as the last tag stage, so no extra register.
  assign pixel_valid = vld_p[STAGES-1];
  assign pixel_owner = own_p[STAGES-1];
  assign pixel_out   = pixel_valid & number_pixel;

endmodule

// File: tb/tb_number_rom_arbiter.sv
// Scoreboard bench for number_rom_arbiter with a registered ROM model.
module tb_number_rom_arbiter;

  localparam int L  = 1;
  localparam int CB = 8;

  logic          clock_25 = 1'b0;
  logic          reset = 1'b1;
  logic          sync_reset = 1'b0;
  logic [2:0]    req = 3'b000;
  logic [3:0]    selected_number_0 = '0, selected_number_1 = '0, selected_number_2 = '0;
  logic [7:0]    number_count_0 = '0, number_count_1 = '0, number_count_2 = '0;
  logic [2:0]    grant, denied;
  logic [3:0]    rom_selected_number;
  logic [7:0]    rom_number_count;
  logic          number_pixel;
  logic          pixel_valid;
  logic [1:0]    pixel_owner;
  logic          pixel_out;
  logic [CB-1:0] conflict_count;

  always #20 clock_25 = ~clock_25;

  number_rom_arbiter #(.ROM_LATENCY(L), .CONFLICT_BITS(CB)) dut (
    .clock_25(clock_25), .reset(reset), .sync_reset(sync_reset), .req(req),
    .selected_number_0(selected_number_0), .selected_number_1(selected_number_1),
    .selected_number_2(selected_number_2), .number_count_0(number_count_0),
    .number_count_1(number_count_1), .number_count_2(number_count_2),
    .grant(grant), .denied(denied), .rom_selected_number(rom_selected_number),
    .rom_number_count(rom_number_count), .number_pixel(number_pixel),
    .pixel_valid(pixel_valid), .pixel_owner(pixel_owner), .pixel_out(pixel_out),
    .conflict_count(conflict_count)
  );

  function automatic logic rom_f(input logic [3:0] sn, input logic [7:0] nc);
    return (^{sn, nc}) ^ nc[2] ^ sn[1];
  endfunction

  logic rom_q;
  always @(posedge clock_25) rom_q <= rom_f(rom_selected_number, rom_number_count);
  assign number_pixel = rom_q;

  int ncyc = 0;
  always @(posedge clock_25) ncyc <= ncyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, ncyc);
    end
  endtask

  typedef struct {
    int         due;
    logic [1:0] own;
    logic       pix;
  } tag_t;
  tag_t sb[$];

  logic [1:0] mptr = 2'd0;
  int         mcnt = 0;
  logic [2:0] egrant, edenied;
  logic [3:0] esn;
  logic [7:0] enc;

  task automatic tick();
    logic [1:0] c, w;
    logic       found;
    logic [2:0] oh;
    tag_t       t;
    found = 1'b0;
    w     = 2'd0;
    c     = mptr;
    for (int k = 0; k < 3; k++) begin
      if (!found && req[c]) begin
        found = 1'b1;
        w     = c;
      end
      c = (c == 2'd2) ? 2'd0 : c + 2'd1;
    end
    if (reset || sync_reset) begin
      egrant = 0; edenied = 0; esn = 0; enc = 0; mptr = 0; mcnt = 0;
      sb.delete();
    end else begin
      if ($countones(req) >= 2 && mcnt < 255) mcnt++;
      if (found) begin
        oh      = 3'b001 << w;
        egrant  = oh;
        edenied = req & ~oh;
        esn     = (w == 0) ? selected_number_0 : (w == 1) ? selected_number_1 : selected_number_2;
        enc     = (w == 0) ? number_count_0 : (w == 1) ? number_count_1 : number_count_2;
        mptr    = (w == 2'd2) ? 2'd0 : w + 2'd1;
        t.due   = ncyc + 1 + L;
        t.own   = w;
        t.pix   = rom_f(esn, enc);
        sb.push_back(t);
      end else begin
        egrant = 0; edenied = 0; esn = 0; enc = 0;
      end
    end
    @(posedge clock_25);
    @(negedge clock_25);
    chk("grant", 32'(grant), 32'(egrant));
    chk("denied", 32'(denied), 32'(edenied));
    chk("rom_sn", 32'(rom_selected_number), 32'(esn));
    chk("rom_nc", 32'(rom_number_count), 32'(enc));
    chk("conflict", 32'(conflict_count), 32'(mcnt));
    if (sb.size() > 0 && sb[0].due == ncyc) begin
      t = sb.pop_front();
      chk("pixel_valid", 32'(pixel_valid), 32'd1);
      chk("pixel_owner", 32'(pixel_owner), 32'(t.own));
      chk("pixel_out", 32'(pixel_out), 32'(t.pix));
    end else begin
      chk("pixel_valid_idle", 32'(pixel_valid), 32'd0);
      chk("pixel_out_idle", 32'(pixel_out), 32'd0);
    end
  endtask

  logic [2:0] seq3 [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

  initial begin
    // 1: reset with idle requests
    reset = 1'b1;
    repeat (5) tick();
    reset = 1'b0;
    repeat (2) tick();

    // 2: single request from requester 1
    req = 3'b010; selected_number_1 = 4'd7; number_count_1 = 8'd35;
    tick();
    req = 3'b000;
    repeat (3) tick();

    // 3: all requesting straight out of reset
    reset = 1'b1; tick(); reset = 1'b0;
    req = 3'b111;
    for (int i = 0; i < 6; i++) begin
      selected_number_0 = 4'(i); number_count_0 = 8'(i * 11);
      selected_number_2 = 4'(i + 3); number_count_2 = 8'(i * 29 + 1);
      tick();
      chk("seq3_grant", 32'(grant), 32'(seq3[i]));
      chk("seq3_denied_pop", $countones(denied), 2);
    end
    req = 3'b000;
    tick();
    chk("seq3_conflict", 32'(conflict_count), 32'd6);
    tick();

    // 4: requesters 0 and 2 alternate from pointer 0
    reset = 1'b1; tick(); reset = 1'b0;
    req = 3'b101;
    for (int i = 0; i < 4; i++) begin
      number_count_0 = 8'(i * 5 + 2); number_count_2 = 8'(i * 7 + 9);
      tick();
      chk("alt_grant", 32'(grant), (i % 2 == 0) ? 32'd1 : 32'd4);
    end
    req = 3'b000;
    repeat (3) tick();

    // 5: saturate conflict counter, then sync_reset
    req = 3'b111;
    repeat (300) tick();
    chk("sat_conflict", 32'(conflict_count), 32'd255);
    sync_reset = 1'b1; tick(); sync_reset = 1'b0;
    chk("sync_clr_conflict", 32'(conflict_count), 32'd0);
    tick();
    chk("sync_first_grant", 32'(grant), 32'd1);
    req = 3'b000;
    repeat (3) tick();

    // 6: grant to requester 2, reset before its pixel returns
    req = 3'b100; selected_number_2 = 4'd9; number_count_2 = 8'd200;
    tick();
    req = 3'b000; reset = 1'b1;
    tick();
    chk("rst_flush_valid", 32'(pixel_valid), 32'd0);
    reset = 1'b0;
    repeat (3) tick();

    // Random traffic with occasional restarts
    for (int i = 0; i < 400; i++) begin
      req = 3'($urandom_range(0, 7));
      selected_number_0 = 4'($urandom); selected_number_1 = 4'($urandom);
      selected_number_2 = 4'($urandom);
      number_count_0 = 8'($urandom); number_count_1 = 8'($urandom);
      number_count_2 = 8'($urandom);
      sync_reset = ($urandom_range(0, 49) == 0);
      reset      = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 1'b0; sync_reset = 1'b0; req = 3'b000;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
